// File: rtl/tone_sequencer.sv
// Queued note player: buffers {duration, note} words and drives the buzzer mode
// input for an exact number of prescaler ticks per note, with an optional silent gap.
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 625000,
    parameter int GAP_TICKS = 1
) (
    input  logic                   clk_62p5mhz,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   clr,
    output logic [7:0]             mode,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   playing,
    output logic                   overflow
);

    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam bit HAS_GAP  = (GAP_TICKS > 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_TICKS);
    localparam logic [GW-1:0] GAP_ONE  = 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [1:0]    r_state;
    logic [7:0]    r_mode;
    logic [7:0]    r_remain;
    logic [GW-1:0] r_gap;
    logic [PW-1:0] r_presc;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic [15:0]   w_head;
    logic [7:0]    w_dur;
    logic          w_note_end;
    logic          w_gap_end;
    logic          w_presc_zero;

    assign w_full       = (r_level == LVL_FULL);
    assign w_empty      = (r_level == '0);
    assign w_push       = wr_en && !w_full && !clr;
    assign w_pop        = (r_state == S_LOAD) && !w_empty;
    assign w_tick       = (r_presc == PRESC_TOP);
    assign w_head       = r_mem[r_rptr];
    assign w_dur        = (w_head[15:8] == 8'd0) ? 8'd1 : w_head[15:8];
    assign w_note_end   = (r_state == S_PLAY) && w_tick && (r_remain == 8'd1);
    assign w_gap_end    = (r_state == S_GAP) && w_tick && (r_gap == GAP_ONE);
    // Restart the prescaler whenever a timed interval begins so its length is exact.
    assign w_presc_zero = (r_state == S_LOAD) || (w_note_end && HAS_GAP);

    always_ff @(posedge clk_62p5mhz) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_62p5mhz) begin
        if (reset || clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (wr_en && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_62p5mhz) begin
        if (reset || clr) begin
            r_presc <= '0;
        end else if (w_presc_zero || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk_62p5mhz) begin
        if (reset || clr) begin
            r_state  <= S_IDLE;
            r_mode   <= 8'd0;
            r_remain <= 8'd0;
            r_gap    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mode <= 8'd0;
                    if (!w_empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_mode   <= w_head[7:0];
                    r_remain <= w_dur;
                    r_state  <= S_PLAY;
                end
                S_PLAY: begin
                    if (w_tick) r_remain <= r_remain - 8'd1;
                    if (w_note_end) begin
                        if (HAS_GAP) begin
                            r_mode  <= 8'd0;
                            r_gap   <= GAP_INIT;
                            r_state <= S_GAP;
                        end else if (!w_empty) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_mode  <= 8'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) r_gap <= r_gap - GAP_ONE;
                    if (w_gap_end) r_state <= w_empty ? S_IDLE : S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mode     = r_mode;
    assign level    = r_level;
    assign full     = w_full;
    assign empty    = w_empty;
    assign playing  = (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule
